// File: rtl/xsim_msg_pkg.sv
// Shared types and header-field constants for the simulator message-source arbiter.
package xsim_msg_pkg;

  // Beat width of every requester stream and of the source channel.
  localparam int BEAT_W = 32;

  typedef logic [BEAT_W-1:0] msg_beat_t;

  // Header beat layout: the length field sits at the bottom of the beat and
  // counts every beat of the message, the header included.
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;

  // Arbiter FSM: IDLE arbitrates and takes a header, BUSY streams the body.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/xsim_msg_arbiter_rr_pick.sv
// Combinational round-robin winner search. The search starts one past the
// last granted requester and wraps, so the previous owner has lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   win_idx,
  output logic               found
);

  logic [IDX_W-1:0] w_cand;

  // Walk the requesters in rotating order and keep the first valid one.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    w_cand  = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
      if (!found && req_valid[w_cand]) begin
        found   = 1'b1;
        win_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/xsim_msg_arbiter.sv
// Message-granular round-robin arbiter in front of the simulator message source.
//
// Handshake: on every requester port and on the output port a beat moves in
// the cycle where valid and ready are both high (req_valid && req_ready on the
// input side, src_rdy && dst_rdy on the output side). A requester holding
// valid must keep its beat stable until it is accepted. The arbiter never
// interleaves messages: once a header is taken, only that requester is served
// until its last beat, even if it goes quiet mid-message.
module xsim_msg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = xsim_msg_pkg::LEN_W
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_beat,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       src_rdy,
  output logic [31:0]                beat,
  input  logic                       dst_rdy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       msg_done,
  output logic                       len_err,
  output logic                       dbg_state
);

  import xsim_msg_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // FSM and arbitration bookkeeping
  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [LEN_W-1:0] r_remaining;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;

  // Output stage
  logic             r_src_rdy;
  msg_beat_t        r_beat;
  logic [IDX_W-1:0] r_grant_id;
  logic             r_msg_done;
  logic             r_len_err;

  // Combinational datapath
  msg_beat_t        w_beats [NUM_REQ];
  logic [IDX_W-1:0] w_win;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  msg_beat_t        w_sel_beat;
  logic             w_sel_valid;
  logic [LEN_W-1:0] w_hdr_len;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_done;
  logic             w_len_err;
  logic [NUM_REQ-1:0] w_req_ready;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_beats[gi] = req_beat[gi*32 +: 32];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .win_idx    (w_win),
    .found      (w_found)
  );

  // The output stage can take a new beat when it is empty or draining now.
  assign w_can_accept = !r_src_rdy || dst_rdy;

  // In IDLE the candidate is the round-robin winner, in BUSY the owner.
  assign w_sel       = (r_state == IDLE) ? w_win : r_grant;
  assign w_sel_beat  = w_beats[w_sel];
  assign w_sel_valid = req_valid[w_sel];
  assign w_hdr_len   = w_sel_beat[LEN_LSB +: LEN_W];

  // Next-state, per-requester ready and completion/length-error decode.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_len_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && w_can_accept) begin
          w_req_ready[w_win] = 1'b1;
          w_accept           = 1'b1;
          w_len_err          = (w_hdr_len == '0);
          // A length of 0 or 1 is a header-only message: done immediately.
          if (w_hdr_len <= LEN_W'(1)) begin
            w_done = 1'b1;
          end else begin
            w_next_state = BUSY;
          end
        end
      end
      BUSY: begin
        w_req_ready[r_grant] = w_can_accept;
        if (w_sel_valid && w_can_accept) begin
          w_accept = 1'b1;
          if (r_remaining <= LEN_W'(1)) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Owner, beats-left counter and round-robin pointer; the counter only
  // moves on accepted beats and never wraps below zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_remaining  <= '0;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_grant     <= w_win;
        r_remaining <= (w_hdr_len == '0) ? '0 : w_hdr_len - LEN_W'(1);
      end else if (r_remaining != '0) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_done) begin
        r_last_grant <= w_sel;
      end
    end
  end

  // Output register: loads every accepted beat, empties when drained with
  // nothing new behind it. Pulses line up with the beat they describe.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_src_rdy  <= 1'b0;
      r_beat     <= '0;
      r_grant_id <= '0;
      r_msg_done <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_msg_done <= w_done;
      r_len_err  <= w_len_err;
      if (w_accept) begin
        r_src_rdy  <= 1'b1;
        r_beat     <= w_sel_beat;
        r_grant_id <= w_sel;
      end else if (dst_rdy) begin
        r_src_rdy <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign src_rdy   = r_src_rdy;
  assign beat      = r_beat;
  assign grant_id  = r_grant_id;
  assign msg_done  = r_msg_done;
  assign len_err   = r_len_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_xsim_msg_arbiter.sv
// Self-checking bench for xsim_msg_arbiter: transaction-level model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_xsim_msg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 16;
  localparam int IDX_W   = 2;

  // ---------------- clock / reset ----------------
  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_beat = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  src_rdy;
  logic [31:0]           beat;
  logic                  dst_rdy = 1'b1;
  logic [IDX_W-1:0]      grant_id;
  logic                  msg_done;
  logic                  len_err;
  logic                  dbg_state;

  always #5 CLK = ~CLK;

  xsim_msg_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_beat  (req_beat),
    .req_ready (req_ready),
    .src_rdy   (src_rdy),
    .beat      (beat),
    .dst_rdy   (dst_rdy),
    .grant_id  (grant_id),
    .msg_done  (msg_done),
    .len_err   (len_err),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] tx_q  [NUM_REQ][$];
  logic [31:0] exp_q [NUM_REQ][$];
  int idle_pct   [NUM_REQ];
  int pause_left [NUM_REQ];
  int pause_at   [NUM_REQ];
  int fire_cnt   [NUM_REQ];
  bit fired      [NUM_REQ];

  logic [31:0] obs_beat[$];
  int          obs_gid[$];
  bit          obs_done[$];
  bit          obs_lerr[$];
  int          obs_cyc[$];
  int          cyc = 0;

  bit          count_stall = 1'b0;
  int          stall_fires = 0;
  bit          stall_prev_valid = 1'b0;
  logic [31:0] stall_prev_beat = '0;

  // ---------------- behavioural model ----------------
  // Owner of the message in flight (-1 = none), beats still owed, last owner.
  int          m_owner = -1;
  int          m_rem   = 0;
  int          m_last  = NUM_REQ - 1;
  bit          m_src_rdy = 1'b0;
  logic [31:0] m_beat  = '0;
  int          m_gid   = 0;
  bit          m_done  = 1'b0;
  bit          m_lerr  = 1'b0;
  bit          m_loaded = 1'b0;

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0] in_beat;
    int win;
    int c;
    int len;
    bit can;
    cyc++;

    check("src_rdy",  {31'd0, src_rdy},   {31'd0, m_src_rdy});
    check("beat",     beat,               m_beat);
    check("grant_id", {30'd0, grant_id},  m_gid);
    check("msg_done", {31'd0, msg_done},  {31'd0, m_done});
    check("len_err",  {31'd0, len_err},   {31'd0, m_lerr});
    check("busy",     {31'd0, dbg_state}, (m_owner >= 0) ? 32'd1 : 32'd0);

    if (m_loaded) begin
      if (exp_q[m_gid].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_content: got 0x%0h from req %0d, required nothing pending", beat, m_gid);
      end else begin
        check("sb_content", beat, exp_q[m_gid].pop_front());
      end
    end

    if (count_stall && stall_prev_valid) begin
      check("bp_hold_valid", {31'd0, src_rdy}, 32'd1);
      check("bp_hold_beat",  beat, stall_prev_beat);
    end
    stall_prev_valid = count_stall && src_rdy && !dst_rdy;
    stall_prev_beat  = beat;

    // Who must be offered ready this cycle.
    can     = !m_src_rdy || dst_rdy;
    exp_rdy = '0;
    win     = -1;
    if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (win < 0 && req_valid[c]) win = c;
      end
      if (win >= 0 && can) exp_rdy[win] = 1'b1;
    end else begin
      win = m_owner;
      exp_rdy[m_owner] = can;
    end
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});

    for (int i = 0; i < NUM_REQ; i++) begin
      fired[i] = req_valid[i] && req_ready[i];
      if (count_stall && fired[i]) stall_fires++;
    end

    if (src_rdy && dst_rdy) begin
      obs_beat.push_back(beat);
      obs_gid.push_back(int'(grant_id));
      obs_done.push_back(msg_done);
      obs_lerr.push_back(len_err);
      obs_cyc.push_back(cyc);
    end

    // Advance the model across the coming clock edge.
    m_loaded = 1'b0;
    m_done   = 1'b0;
    m_lerr   = 1'b0;
    if (!RST_N) begin
      m_owner   = -1;
      m_rem     = 0;
      m_last    = NUM_REQ - 1;
      m_src_rdy = 1'b0;
      m_beat    = '0;
      m_gid     = 0;
    end else if (win >= 0 && exp_rdy[win] && req_valid[win]) begin
      in_beat   = req_beat[win*32 +: 32];
      m_loaded  = 1'b1;
      m_src_rdy = 1'b1;
      m_beat    = in_beat;
      m_gid     = win;
      if (m_owner < 0) begin
        len    = int'(in_beat[LEN_W-1:0]);
        m_lerr = (len == 0);
        if (len <= 1) begin
          m_done = 1'b1;
          m_last = win;
        end else begin
          m_owner = win;
          m_rem   = len - 1;
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_done  = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end else if (dst_rdy) begin
      m_src_rdy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_step();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fired[i]) begin
        void'(tx_q[i].pop_front());
        fire_cnt[i]++;
        if (fire_cnt[i] == pause_at[i]) pause_left[i] = 3;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i]) begin
        if (pause_left[i] > 0) begin
          pause_left[i]--;
        end else if (tx_q[i].size() > 0 && $urandom_range(0, 99) >= idle_pct[i]) begin
          req_valid[i] = 1'b1;
          req_beat[i*32 +: 32] = tx_q[i][0];
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      drive_step();
    end
  endtask

  task automatic send_msg(input int r, input logic [31:0] hdr, input int nbody, input logic [31:0] base);
    tx_q[r].push_back(hdr);
    exp_q[r].push_back(hdr);
    for (int b = 1; b <= nbody; b++) begin
      tx_q[r].push_back(base + b);
      exp_q[r].push_back(base + b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (tx_q[i].size() != 0 || exp_q[i].size() != 0 || req_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int t = 0;
    while (!all_empty() && t < budget) begin
      run_cycles(1);
      t++;
    end
    n_checks++;
    if (!all_empty()) begin
      n_fail++;
      $display("FAIL %s_drain: messages still pending after %0d cycles, required none", name, budget);
    end
    run_cycles(2);
  endtask

  task automatic clear_obs();
    obs_beat.delete();
    obs_gid.delete();
    obs_done.delete();
    obs_lerr.delete();
    obs_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) fire_cnt[i] = 0;
  endtask

  task automatic expect_obs(input string name, input logic [31:0] eb[$], input int eg[$]);
    check({name, "_count"}, obs_beat.size(), eb.size());
    for (int k = 0; k < eb.size() && k < obs_beat.size(); k++) begin
      check({name, "_beat"}, obs_beat[k], eb[k]);
      check({name, "_gid"},  obs_gid[k],  eg[k]);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] eb[$];
    int eg[$];
    int t;

    for (int i = 0; i < NUM_REQ; i++) begin
      idle_pct[i]   = 0;
      pause_left[i] = 0;
      pause_at[i]   = -1;
      fire_cnt[i]   = 0;
      fired[i]      = 1'b0;
    end

    repeat (3) @(posedge CLK);
    #1;
    check("rst_src_rdy",   {31'd0, src_rdy},   32'd0);
    check("rst_beat",      beat,               32'd0);
    check("rst_grant_id",  {30'd0, grant_id},  32'd0);
    check("rst_msg_done",  {31'd0, msg_done},  32'd0);
    check("rst_len_err",   {31'd0, len_err},   32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_state",     {31'd0, dbg_state}, 32'd0);
    RST_N = 1'b1;

    // Single requester, three-beat message.
    clear_obs();
    send_msg(0, 32'h0000_0003, 2, 32'hA0);
    drain("single", 50);
    eb = {32'h3, 32'hA1, 32'hA2};
    eg = {0, 0, 0};
    expect_obs("single", eb, eg);
    if (obs_beat.size() == 3) begin
      check("single_done_last", {31'd0, obs_done[2]}, 32'd1);
      check("single_done_early", {31'd0, obs_done[0] | obs_done[1]}, 32'd0);
      check("single_back_to_back", obs_cyc[2] - obs_cyc[0], 32'd2);
    end

    // Contention: req1 and req2 together, req1 wins, no bubble between.
    clear_obs();
    send_msg(1, 32'h2, 1, 32'hB0);
    send_msg(2, 32'h2, 1, 32'hC0);
    drain("contend", 50);
    eb = {32'h2, 32'hB1, 32'h2, 32'hC1};
    eg = {1, 1, 2, 2};
    expect_obs("contend", eb, eg);
    if (obs_beat.size() == 4) begin
      check("contend_no_bubble", obs_cyc[3] - obs_cyc[0], 32'd3);
      check("contend_done1", {31'd0, obs_done[1]}, 32'd1);
    end

    // Second round after req2: req3 is next in line.
    clear_obs();
    send_msg(3, 32'h2, 1, 32'hD0);
    send_msg(0, 32'h2, 1, 32'hE0);
    drain("contend_r2", 50);
    eb = {32'h2, 32'hD1, 32'h2, 32'hE1};
    eg = {3, 3, 0, 0};
    expect_obs("contend_r2", eb, eg);

    // After req2 with req3 absent the pointer wraps to req0.
    clear_obs();
    send_msg(2, 32'h1, 0, 32'h0);
    drain("wrap_pre", 50);
    clear_obs();
    send_msg(1, 32'h2, 1, 32'h40);
    send_msg(0, 32'h2, 1, 32'h30);
    drain("wrap", 50);
    eb = {32'h2, 32'h31, 32'h2, 32'h41};
    eg = {0, 0, 1, 1};
    expect_obs("wrap", eb, eg);

    // No interleave: req0 goes quiet for 3 cycles mid-message.
    clear_obs();
    pause_at[0] = 2;
    send_msg(0, 32'h4, 3, 32'hF0);
    run_cycles(1);
    send_msg(1, 32'h2, 1, 32'h50);
    drain("nointerleave", 80);
    pause_at[0] = -1;
    eb = {32'h4, 32'hF1, 32'hF2, 32'hF3, 32'h2, 32'h51};
    eg = {0, 0, 0, 0, 1, 1};
    expect_obs("nointerleave", eb, eg);
    if (obs_cyc.size() == 6) check("nointerleave_gap", obs_cyc[2] - obs_cyc[1], 32'd4);

    // Backpressure: downstream stalls for 5 cycles mid-message.
    clear_obs();
    send_msg(2, 32'h5, 4, 32'h60);
    t = 0;
    while (obs_beat.size() < 2 && t < 30) begin
      run_cycles(1);
      t++;
    end
    check("bp_reach_stall", {31'd0, obs_beat.size() >= 2}, 32'd1);
    stall_fires = 0;
    count_stall = 1'b1;
    dst_rdy     = 1'b0;
    run_cycles(5);
    count_stall = 1'b0;
    dst_rdy     = 1'b1;
    check("bp_stall_accepts", {31'd0, stall_fires <= 1}, 32'd1);
    drain("bp", 50);
    eb = {32'h5, 32'h61, 32'h62, 32'h63, 32'h64};
    eg = {2, 2, 2, 2, 2};
    expect_obs("bp", eb, eg);

    // Zero-length header is a single beat with both pulses.
    clear_obs();
    send_msg(2, 32'h0000_0000, 0, 32'h0);
    drain("zero", 50);
    eb = {32'h0};
    eg = {2};
    expect_obs("zero", eb, eg);
    if (obs_beat.size() == 1) begin
      check("zero_done", {31'd0, obs_done[0]}, 32'd1);
      check("zero_lerr", {31'd0, obs_lerr[0]}, 32'd1);
    end
    check("zero_state_idle", {31'd0, dbg_state}, 32'd0);

    // Reset in the middle of a five-beat message.
    clear_obs();
    send_msg(1, 32'h5, 4, 32'h70);
    t = 0;
    while (fire_cnt[1] < 1 && t < 30) begin
      run_cycles(1);
      t++;
    end
    check("mid_rst_reach", {31'd0, fire_cnt[1] >= 1}, 32'd1);
    RST_N     = 1'b0;
    req_valid = '0;
    @(posedge CLK);
    #1;
    check("mid_rst_src_rdy",   {31'd0, src_rdy},   32'd0);
    check("mid_rst_beat",      beat,               32'd0);
    check("mid_rst_grant_id",  {30'd0, grant_id},  32'd0);
    check("mid_rst_msg_done",  {31'd0, msg_done},  32'd0);
    check("mid_rst_len_err",   {31'd0, len_err},   32'd0);
    check("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("mid_rst_state",     {31'd0, dbg_state}, 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_q[i].delete();
      exp_q[i].delete();
      pause_left[i] = 0;
    end
    clear_obs();
    send_msg(3, 32'h2, 1, 32'h90);
    send_msg(0, 32'h2, 1, 32'h80);
    drain("post_rst", 50);
    eb = {32'h2, 32'h81, 32'h2, 32'h91};
    eg = {0, 0, 3, 3};
    expect_obs("post_rst", eb, eg);

    // Randomized soak against the model.
    for (int i = 0; i < NUM_REQ; i++) idle_pct[i] = $urandom_range(0, 60);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 30) begin
        int r;
        int len;
        r   = $urandom_range(0, NUM_REQ - 1);
        len = $urandom_range(0, 6);
        if (tx_q[r].size() < 10)
          send_msg(r, {16'($urandom), 16'(len)}, (len <= 1) ? 0 : len - 1, 32'($urandom) & 32'hFFFF_FF00);
      end
      if (n % 500 == 0)
        for (int i = 0; i < NUM_REQ; i++) idle_pct[i] = $urandom_range(0, 60);
      dst_rdy = ($urandom_range(0, 99) < 75);
      run_cycles(1);
    end
    dst_rdy = 1'b1;
    drain("random", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xsim_msg_arbiter.md
# xsim_msg_arbiter

Round-robin, message-granular arbiter that shares the single simulator message-source channel among `NUM_REQ` portal requesters. Each requester presents a stream of 32-bit beats forming framed messages. The arbiter grants one requester at a time and forwards that requester's whole message, header through last beat, without interleaving. It presents the result on a registered output stage that drives the DPI beat source (`src_rdy`/`beat`). It sits between the portal wrappers in `mkXsimTop` and the message-source bridge.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `LEN_W`, default 16: width of the length field in the header beat.

Ports:
- `CLK` in 1: sole clock; all state updates on posedge.
- `RST_N` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_beat` in NUM_REQ*32: per-requester beat; requester i uses bits [32i+31:32i].
- `req_ready` out NUM_REQ: per-requester accept; a beat transfers when valid && ready.
- `src_rdy` out 1: output beat valid.
- `beat` out 32: output beat.
- `dst_rdy` in 1: downstream accept; tie high for the DPI source, which never stalls.
- `grant_id` out $clog2(NUM_REQ): requester owning the beat on `beat`.
- `msg_done` out 1: one-cycle pulse when the last beat of a message is accepted from a requester.
- `len_err` out 1: one-cycle pulse when a header with length field 0 is accepted.

## Operation
- **Header format:** header `beat[LEN_W-1:0]` = total message length in beats, header included. Length 0 is treated as 1 (header-only) and pulses `len_err`.
- **FSM states:**
  - IDLE: arbitrate among `req_valid`.
  - BUSY: stream from the granted requester.
- **IDLE → BUSY:** when some `req_valid` is set and the output stage can accept (`!src_rdy || dst_rdy`). Then:
  - the winner's header is accepted that cycle;
  - `remaining` = len-1;
  - `grant` = winner.
  - If len ≤ 1, stay IDLE and pulse `msg_done`.
- **Round-robin search:** starts at `last_grant+1` modulo NUM_REQ. `last_grant` resets to NUM_REQ-1, so requester 0 has first priority.
- **BUSY:**
  - `req_ready[grant]` = output-stage-can-accept; all other `req_ready` are 0.
  - Each accepted beat decrements `remaining`.
  - On the beat that makes `remaining` 0: pulse `msg_done`, set `last_grant` = `grant`, go to IDLE.
- **No pre-emption:** a granted requester that deasserts `req_valid` mid-message stalls the arbiter. Other requesters stay blocked until that message completes.
- **Output stage:** a single register holding `beat` and `grant_id`, with `src_rdy` as its valid.
  - Loads on any accepted requester beat.
  - Clears `src_rdy` when `dst_rdy` is high and no new beat loads.
- **`remaining` counter:** LEN_W bits, never wraps. Decrements only on accepted beats.

## Timing
- **Reset values:** `src_rdy`=0, `beat`=0, `grant_id`=0, `req_ready`=0, `msg_done`=0, `len_err`=0, state IDLE, `remaining`=0, `last_grant`=NUM_REQ-1. Reset mid-message drops the partial message; no completion pulse is produced.
- **`req_ready`:** combinational from state, `req_valid`, `src_rdy` and `dst_rdy`. In IDLE only the winner sees ready.
- **Latency:** 1 cycle from requester acceptance to `src_rdy`/`beat`.
- **Throughput:** with `dst_rdy` held high, 1 beat/cycle. Zero bubble between messages: the cycle after a last beat is IDLE and accepts the next header.
- **`msg_done` and `len_err`:** asserted in the cycle after the qualifying acceptance, aligned with that beat appearing on the output.
- **Simultaneous headers** in IDLE: the round-robin winner only; losers see `req_ready`=0 and must hold their beats.

## Structure
- Package `xsim_msg_pkg`:
  - `typedef logic [31:0] msg_beat_t`;
  - header length field constants (`LEN_LSB`=0, `LEN_W`);
  - FSM state enum {IDLE, BUSY}.
- Sub-module `rr_pick`: combinational round-robin winner from `req_valid` and `last_grant`. Outputs index and a found flag.
- Output register and FSM live in the top.

## Test plan
- **Single requester:** req0 sends header len=3 (0x0000_0003), then 0xA1, 0xA2, `dst_rdy`=1.
  - `src_rdy` high for cycles 1..3 with beats 0x3, 0xA1, 0xA2; `grant_id`=0.
  - `msg_done` pulses with 0xA2.
- **Contention:** req1 and req2 both present len=2 headers at cycle 0.
  - req1 is served first, 2 beats; req2 follows with no bubble.
  - A second contention round starts with req3 if it is valid, otherwise wraps to 0.
- **No interleave:** req0 sends len=4 and drops `req_valid` for 3 cycles after beat 2 while req1 is valid.
  - Output idles; `req_ready[1]`=0 throughout; req0's message completes before req1's header.
- **Backpressure:** `dst_rdy`=0 for 5 cycles mid-message.
  - `src_rdy` and `beat` hold stable; at most one beat is accepted into the stage.
  - Message order and content are preserved.
- **Zero length:** header 0x0000_0000 on req2.
  - Forwarded as a single beat; `len_err` and `msg_done` pulse together; state stays IDLE.
- **Reset mid-message:** `RST_N`=0 for 1 cycle after beat 1 of a len=5 message.
  - All outputs return to their reset values the next cycle.
  - A new header from req0 is then served first.
